// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD time-digit cells.
// Binary-to-BCD conversion derives reset and terminal digit pairs.
package clock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic [2*DIGIT_W-1:0] to_bcd(input int unsigned v);
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] ones;
    tens = DIGIT_W'(v / 10);
    ones = DIGIT_W'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// Single BCD digit increment/decrement with a per-call limit.
// Up wraps past lim to 0; down wraps past 0 to lim.
module bcd_digit_step
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] d,
  input  logic               en,
  input  logic               up,
  input  logic [DIGIT_W-1:0] lim,
  output logic [DIGIT_W-1:0] nxt,
  output logic               wrap
);

  always_comb begin
    nxt  = d;
    wrap = 1'b0;
    if (en) begin
      if (up == DIR_UP) begin
        if (d >= lim) begin
          nxt  = '0;
          wrap = 1'b1;
        end else begin
          nxt = d + 1'b1;
        end
      end else begin
        if (d == '0) begin
          nxt  = lim;
          wrap = 1'b1;
        end else begin
          nxt = d - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter with load, clear and cascade carry.
// Tens digit steps only when the ones digit wraps.
module bcd_mod_counter #(
  parameter int MOD  = 60,
  parameter bit WRAP = 1'b1,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_time,
  input  logic       enable,
  input  logic       up_down,
  input  logic       clear,
  input  logic       load_enable,
  input  logic [3:0] set_value1,
  input  logic [3:0] set_value10,
  output logic [3:0] dec1,
  output logic [3:0] dec10,
  output logic       carry,
  output logic       at_terminal,
  output logic       load_err
);
  import clock_pkg::*;

  localparam logic [7:0] INIT_BCD = to_bcd(INIT);
  localparam logic [7:0] MAX_BCD  = to_bcd(MOD - 1);
  localparam logic [3:0] MAX1     = MAX_BCD[3:0];
  localparam logic [3:0] MAX10    = MAX_BCD[7:4];
  localparam logic [7:0] MOD_B    = 8'(MOD);

  logic [3:0] lim1;
  logic [3:0] nxt1;
  logic [3:0] nxt10;
  logic       w1;
  logic       w10;
  logic [7:0] ld_val;
  logic       ld_ok;
  logic       tick;

  // Ones limit shrinks to MAX1 only on the top (up) or bottom (down) decade.
  always_comb begin
    lim1 = 4'd9;
    if (up_down == DIR_UP) begin
      if (dec10 == MAX10) lim1 = MAX1;
    end else begin
      if (dec10 == 4'd0) lim1 = MAX1;
    end
  end

  bcd_digit_step u_ones (
    .d    (dec1),
    .en   (1'b1),
    .up   (up_down),
    .lim  (lim1),
    .nxt  (nxt1),
    .wrap (w1)
  );

  bcd_digit_step u_tens (
    .d    (dec10),
    .en   (w1),
    .up   (up_down),
    .lim  (MAX10),
    .nxt  (nxt10),
    .wrap (w10)
  );

  assign ld_val = {4'd0, set_value10} * 8'd10 + {4'd0, set_value1};
  assign ld_ok  = (set_value1 <= 4'd9) && (set_value10 <= 4'd9)
               && (ld_val < MOD_B);
  assign tick   = clk_time && enable;

  assign at_terminal = (up_down == DIR_UP) ? ({dec10, dec1} == MAX_BCD)
                                           : ({dec10, dec1} == 8'd0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      {dec10, dec1} <= INIT_BCD;
      carry         <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clear) begin
        {dec10, dec1} <= INIT_BCD;
      end else if (load_enable) begin
        if (ld_ok) {dec10, dec1} <= {set_value10, set_value1};
        else       load_err      <= 1'b1;
      end else if (tick && (WRAP || !w10)) begin
        dec1  <= nxt1;
        dec10 <= nxt10;
        carry <= w10;
      end
    end
  end

endmodule
